// File: rtl/tip_hello_reset_sequencer.sv
// Platform reset sequencer: once the PLL is locked it releases peripheral, DRAM
// and core resets in order, and offers a software warm reset that spares DRAM.
module tip_hello_reset_sequencer #(
    parameter int LOCK_SETTLE_CYCLES   = 16,
    parameter int STAGE_GAP_CYCLES     = 8,
    parameter int CALIB_TIMEOUT_CYCLES = 1024,
    parameter int SW_RESET_HOLD_CYCLES = 32,
    parameter int DRAM_ENABLE          = 1
) (
    input  logic       clk_system,
    input  logic       rst_system,
    input  logic       pll_locked,
    input  logic       dram_calib_done,
    input  logic       sw_reset_req,
    output logic       peri_rstnn,
    output logic       dram_rstnn,
    output logic       core_rstnn,
    output logic [2:0] seq_state,
    output logic       calib_timeout
);

    function automatic int max2(int a, int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CNT = max2(max2(LOCK_SETTLE_CYCLES, STAGE_GAP_CYCLES),
                                  max2(CALIB_TIMEOUT_CYCLES, SW_RESET_HOLD_CYCLES));
    localparam int CNT_W   = $clog2(MAX_CNT) + 1;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(LOCK_SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CALIB_LAST  = CNT_W'(CALIB_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(SW_RESET_HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        RESET      = 3'd0,
        WAIT_LOCK  = 3'd1,
        SETTLE     = 3'd2,
        REL_PERI   = 3'd3,
        WAIT_CALIB = 3'd4,
        REL_CORE   = 3'd5,
        RUN        = 3'd6,
        SW_HOLD    = 3'd7
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             lock_meta;
    logic             lock_sync;
    logic             calib_meta;
    logic             calib_sync;
    logic             peri_next;
    logic             dram_next;
    logic             core_next;
    logic             timeout_set;

    always_ff @(posedge clk_system) begin
        if (rst_system) begin
            lock_meta  <= 1'b0;
            lock_sync  <= 1'b0;
            calib_meta <= 1'b0;
            calib_sync <= 1'b0;
        end else begin
            lock_meta  <= pll_locked;
            lock_sync  <= lock_meta;
            calib_meta <= dram_calib_done;
            calib_sync <= calib_meta;
        end
    end

    always_ff @(posedge clk_system) begin
        if (rst_system) begin
            state         <= RESET;
            cnt           <= '0;
            peri_rstnn    <= 1'b0;
            dram_rstnn    <= 1'b0;
            core_rstnn    <= 1'b0;
            calib_timeout <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= (state_next != state) ? '0 : cnt + 1'b1;
            peri_rstnn    <= peri_next;
            dram_rstnn    <= dram_next;
            core_rstnn    <= core_next;
            calib_timeout <= calib_timeout | timeout_set;
        end
    end

    always_comb begin
        state_next  = state;
        timeout_set = 1'b0;
        // Losing lock anywhere past WAIT_LOCK outranks timers and warm-reset requests.
        if (state inside {SETTLE, REL_PERI, WAIT_CALIB, REL_CORE, RUN, SW_HOLD} && !lock_sync) begin
            state_next = WAIT_LOCK;
        end else begin
            case (state)
                RESET:      state_next = WAIT_LOCK;
                WAIT_LOCK:  if (lock_sync) state_next = SETTLE;
                SETTLE:     if (cnt == SETTLE_LAST) state_next = REL_PERI;
                REL_PERI:   if (cnt == GAP_LAST)
                                state_next = (DRAM_ENABLE != 0) ? WAIT_CALIB : REL_CORE;
                WAIT_CALIB: begin
                    if (calib_sync) begin
                        state_next = REL_CORE;
                    end else if (cnt == CALIB_LAST) begin
                        state_next  = REL_CORE;
                        timeout_set = 1'b1;
                    end
                end
                REL_CORE:   if (cnt == GAP_LAST) state_next = RUN;
                RUN:        if (sw_reset_req) state_next = SW_HOLD;
                SW_HOLD:    if (cnt == HOLD_LAST) state_next = REL_PERI;
                default:    state_next = RESET;
            endcase
        end

        // Outputs are decoded from the upcoming state so they move on the entry edge.
        peri_next = state_next inside {REL_PERI, WAIT_CALIB, REL_CORE, RUN};
        core_next = (state_next == RUN);
        case (state_next)
            RESET, WAIT_LOCK: dram_next = 1'b0;
            WAIT_CALIB:       dram_next = 1'b1;
            default:          dram_next = dram_rstnn;
        endcase
    end

    assign seq_state = state;

endmodule

// File: tb/tb_tip_hello_reset_sequencer.sv
// Scoreboard bench: a countdown-timer reference model predicts every output change
// of a DRAM-enabled and a DRAM-less sequencer; a monitor matches the DUT changes.
module tb_tip_hello_reset_sequencer;

    localparam int SETTLE = 16;
    localparam int GAP    = 8;
    localparam int TMO    = 1024;
    localparam int HOLD   = 32;

    logic clk_system      = 1'b0;
    logic rst_system      = 1'b1;
    logic pll_locked      = 1'b0;
    logic dram_calib_done = 1'b0;
    logic sw_reset_req    = 1'b0;

    logic       peri [2];
    logic       dram [2];
    logic       core [2];
    logic       tmo  [2];
    logic [2:0] st   [2];

    tip_hello_reset_sequencer #(.DRAM_ENABLE(1)) u_dram (
        .clk_system(clk_system), .rst_system(rst_system), .pll_locked(pll_locked),
        .dram_calib_done(dram_calib_done), .sw_reset_req(sw_reset_req),
        .peri_rstnn(peri[0]), .dram_rstnn(dram[0]), .core_rstnn(core[0]),
        .seq_state(st[0]), .calib_timeout(tmo[0]));

    tip_hello_reset_sequencer #(.DRAM_ENABLE(0)) u_nodram (
        .clk_system(clk_system), .rst_system(rst_system), .pll_locked(pll_locked),
        .dram_calib_done(dram_calib_done), .sw_reset_req(sw_reset_req),
        .peri_rstnn(peri[1]), .dram_rstnn(dram[1]), .core_rstnn(core[1]),
        .seq_state(st[1]), .calib_timeout(tmo[1]));

    always #5 clk_system = ~clk_system;

    typedef struct {
        int st;
        int left;
        bit peri, dram, core, to;
        bit l0, l1, c0, c1;
    } mdl_t;

    typedef struct {
        int         cyc;
        int         inst;
        logic [6:0] val;
    } ev_t;

    mdl_t       m [2];
    ev_t        sbq [$];
    logic [6:0] prev [2];
    int         cyc    = 0;
    int         n_chk  = 0;
    int         n_fail = 0;

    function automatic logic [6:0] pack_m(mdl_t x);
        return {3'(x.st), x.peri, x.dram, x.core, x.to};
    endfunction

    // One clock edge of the reference: named states, countdown of remaining cycles,
    // outputs toggled by the event of entering a state.
    function automatic mdl_t step(mdl_t x, bit rst, bit lk, bit cal, bit sw, bit den);
        mdl_t y;
        bit   ls;
        bit   cs;
        y  = x;
        ls = x.l1;
        cs = x.c1;
        if (rst) begin
            y = '{default: 0};
            return y;
        end
        y.l1 = x.l0; y.l0 = lk;
        y.c1 = x.c0; y.c0 = cal;
        if (x.st >= 2 && !ls) begin
            y.st = 1; y.peri = 0; y.dram = 0; y.core = 0;
            return y;
        end
        case (x.st)
            0: y.st = 1;
            1: if (ls) begin y.st = 2; y.left = SETTLE; end
            2: begin
                y.left = y.left - 1;
                if (y.left == 0) begin y.st = 3; y.left = GAP; y.peri = 1; end
            end
            3: begin
                y.left = y.left - 1;
                if (y.left == 0) begin
                    if (den) begin y.st = 4; y.left = TMO; y.dram = 1; end
                    else begin y.st = 5; y.left = GAP; end
                end
            end
            4: begin
                if (cs) begin
                    y.st = 5; y.left = GAP;
                end else begin
                    y.left = y.left - 1;
                    if (y.left == 0) begin y.to = 1; y.st = 5; y.left = GAP; end
                end
            end
            5: begin
                y.left = y.left - 1;
                if (y.left == 0) begin y.st = 6; y.core = 1; end
            end
            6: if (sw) begin y.st = 7; y.left = HOLD; y.core = 0; y.peri = 0; end
            7: begin
                y.left = y.left - 1;
                if (y.left == 0) begin y.st = 3; y.left = GAP; y.peri = 1; end
            end
            default: y.st = 0;
        endcase
        return y;
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin
            m[i]    = '{default: 0};
            prev[i] = '0;
        end
    end

    always @(posedge clk_system) begin
        for (int i = 0; i < 2; i++) begin
            mdl_t nx;
            ev_t  e;
            nx = step(m[i], rst_system, pll_locked, dram_calib_done, sw_reset_req, i == 0);
            if (pack_m(nx) != pack_m(m[i])) begin
                e.cyc = cyc + 1; e.inst = i; e.val = pack_m(nx);
                sbq.push_back(e);
            end
            m[i] = nx;
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk_system) begin
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            n_chk++; n_fail++;
            $display("FAIL missed_change inst%0d cyc %0d: DUT unchanged, required {st,peri,dram,core,to}=%b",
                     sbq[0].inst, sbq[0].cyc, sbq[0].val);
            sbq.delete(0);
        end
        for (int i = 0; i < 2; i++) begin
            logic [6:0] a;
            int         k;
            a = {st[i], peri[i], dram[i], core[i], tmo[i]};
            if (a !== prev[i]) begin
                prev[i] = a;
                k = -1;
                for (int j = 0; j < sbq.size(); j++)
                    if (k < 0 && sbq[j].cyc == cyc && sbq[j].inst == i) k = j;
                n_chk++;
                if (k < 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change inst%0d cyc %0d: actual %b, required no change",
                             i, cyc, a);
                end else begin
                    if (sbq[k].val !== a) begin
                        n_fail++;
                        $display("FAIL output_change inst%0d cyc %0d: actual %b, required %b",
                                 i, cyc, a, sbq[k].val);
                    end
                    sbq.delete(k);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_system);
    endtask

    task automatic wait_state(input int s, input int budget);
        int k;
        k = 0;
        while (st[0] != 3'(s) && k < budget) begin
            @(negedge clk_system);
            k++;
        end
        if (st[0] != 3'(s)) begin
            n_chk++; n_fail++;
            $display("FAIL wait_state: actual state %0d, required %0d within %0d cycles",
                     st[0], s, budget);
        end
    endtask

    task automatic sw_pulse();
        sw_reset_req = 1'b1;
        cycles(1);
        sw_reset_req = 1'b0;
    endtask

    task automatic lock_drop(input int n);
        pll_locked = 1'b0;
        cycles(n);
        pll_locked = 1'b1;
    endtask

    initial begin
        pll_locked      = 1'b1;
        dram_calib_done = 1'b1;
        cycles(3);
        n_chk++;
        if ({st[0], peri[0], dram[0], core[0], tmo[0], st[1], peri[1], dram[1], core[1], tmo[1]} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: actual %b/%b, required all zero",
                     {st[0], peri[0], dram[0], core[0], tmo[0]},
                     {st[1], peri[1], dram[1], core[1], tmo[1]});
        end
        rst_system = 1'b0;

        // nominal bring-up, then lock loss 5 cycles into RUN and relock
        wait_state(6, 200);
        cycles(5);
        lock_drop(4);
        wait_state(6, 200);
        cycles(10);

        // calibration never completes: full timeout, then lock loss keeps the flag
        dram_calib_done = 1'b0;
        lock_drop(3);
        wait_state(6, 1300);
        cycles(3);
        dram_calib_done = 1'b1;
        lock_drop(3);
        wait_state(6, 200);
        cycles(4);

        // warm reset, plus a second request while held that must be ignored
        sw_pulse();
        cycles(10);
        sw_pulse();
        wait_state(6, 200);
        cycles(3);

        // master reset in the middle of WAIT_CALIB
        dram_calib_done = 1'b0;
        lock_drop(3);
        wait_state(4, 200);
        cycles(10);
        rst_system = 1'b1;
        cycles(1);
        rst_system = 1'b0;
        wait_state(4, 200);
        dram_calib_done = 1'b1;
        wait_state(6, 200);
        cycles(5);

        // master reset on the same edge as a warm-reset request and lock loss
        rst_system   = 1'b1;
        sw_reset_req = 1'b1;
        pll_locked   = 1'b0;
        cycles(1);
        rst_system   = 1'b0;
        sw_reset_req = 1'b0;
        pll_locked   = 1'b1;
        wait_state(6, 200);
        cycles(5);

        // randomized mix of all events
        repeat (300) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: sw_pulse();
                4:          lock_drop($urandom_range(1, 3));
                5:          dram_calib_done = ~dram_calib_done;
                6:          begin rst_system = 1'b1; cycles(1); rst_system = 1'b0; end
                default:    ;
            endcase
            cycles($urandom_range(1, 40));
        end

        pll_locked      = 1'b1;
        dram_calib_done = 1'b1;
        cycles(1200);
        n_chk++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_events: actual %0d pending, required 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tip_hello_reset_sequencer.md
Name: tip_hello_reset_sequencer

Overview:
- Sits directly downstream of the platform clock/PLL stage and runs on the `clk_system` it produces.
- Watches the PLL lock and DRAM calibration status and releases the platform resets in a fixed order: peripheral, then DRAM, then core.
- Re-asserts all resets if lock is lost.
- Provides a software-requested warm reset of core and peripherals that leaves the DRAM controller running.

Parameters:
- LOCK_SETTLE_CYCLES, 16: cycles of stable lock required before the first reset is released (>=1).
- STAGE_GAP_CYCLES, 8: cycles between consecutive reset release stages (>=1).
- CALIB_TIMEOUT_CYCLES, 1024: maximum wait for DRAM calibration before proceeding (>=1).
- SW_RESET_HOLD_CYCLES, 32: hold time of a software warm reset (>=1).
- DRAM_ENABLE, 1: 0 = no DRAM; the calibration wait is skipped and dram_rstnn stays low.

Ports:
- clk_system  in  1  system clock from the PLL stage
- rst_system  in  1  synchronous, active-high master reset
- pll_locked  in  1  PLL lock, asynchronous; 2-flop synchronised internally
- dram_calib_done  in  1  DRAM calibration done, asynchronous; 2-flop synchronised internally
- sw_reset_req  in  1  single-cycle warm-reset request, synchronous to clk_system
- peri_rstnn  out  1  peripheral reset, active-low, registered
- dram_rstnn  out  1  DRAM controller reset, active-low, registered
- core_rstnn  out  1  core reset, active-low, registered
- seq_state  out  3  current FSM state encoding
- calib_timeout  out  1  sticky flag: calibration timed out

Behaviour:
- Clock and reset: one clock, clk_system. rst_system is synchronous and active-high.
- While rst_system=1:
  - all three *_rstnn outputs = 0; calib_timeout = 0; seq_state = RESET (0).
  - synchroniser flops = 0; counter = 0.
- rst_system has priority over every other event, including mid-sequence.
- Synchronisers: an input change is visible to the FSM 2 edges after it is sampled.
- Counter: a single shared counter, width $clog2 of the largest count parameter, plus 1 bit. It is cleared on every state entry. Each timed state lasts exactly N cycles, then transitions.
- States and transitions:
  - RESET (0): leave on the first edge with rst_system=0, go to WAIT_LOCK.
  - WAIT_LOCK (1): when synced lock=1, go to SETTLE.
  - SETTLE (2): after LOCK_SETTLE_CYCLES cycles, go to REL_PERI.
  - REL_PERI (3): peri_rstnn=1. After STAGE_GAP_CYCLES cycles:
    - DRAM_ENABLE=1: go to WAIT_CALIB.
    - DRAM_ENABLE=0: go to REL_CORE.
  - WAIT_CALIB (4): dram_rstnn=1.
    - If synced calib=1, go to REL_CORE.
    - Otherwise, after CALIB_TIMEOUT_CYCLES cycles, set calib_timeout=1 and go to REL_CORE.
  - REL_CORE (5): after STAGE_GAP_CYCLES cycles, go to RUN.
  - RUN (6): core_rstnn=1.
  - SW_HOLD (7): core_rstnn=0 and peri_rstnn=0; dram_rstnn holds its current value. After SW_RESET_HOLD_CYCLES cycles, go to REL_PERI.
- Output timing: each output changes on the same edge that enters the state that changes it.
- Lock loss: synced lock=0 in any state from SETTLE through SW_HOLD:
  - next edge: all *_rstnn=0 and state = WAIT_LOCK.
  - calib_timeout is retained.
  - Lock loss has priority over sw_reset_req and over any counter expiry on the same edge.
- sw_reset_req:
  - acted on only in RUN; ignored in all other states, with no queuing.
  - a request on the same cycle as lock loss is dropped.
- Re-entering WAIT_CALIB when calib is already high costs exactly one cycle in WAIT_CALIB.
- calib_timeout is cleared only by rst_system.

Test Plan:
- Reset, then pll_locked=1 and dram_calib_done=1 held; defaults.
  - Required: state 0→1→2. peri_rstnn rises 16 cycles after SETTLE entry. dram_rstnn rises 8 cycles later. WAIT_CALIB lasts 1 cycle. core_rstnn rises 8 cycles after REL_CORE entry. calib_timeout=0.
- pll_locked deasserted 5 cycles into RUN.
  - Required: 2 cycles later (sync), all *_rstnn=0 on one edge and state=1.
  - Relock: full sequence repeats with identical spacing.
- dram_calib_done held 0, CALIB_TIMEOUT_CYCLES=1024.
  - Required: WAIT_CALIB lasts exactly 1024 cycles; calib_timeout=1; core_rstnn rises 8 cycles later.
  - Required: calib_timeout stays 1 through a subsequent lock-loss cycle.
- sw_reset_req pulse in RUN.
  - Required: next edge core_rstnn=0, peri_rstnn=0, dram_rstnn stays 1.
  - Required: 32 cycles later peri_rstnn=1; core_rstnn back to 1 after 8+1+8 cycles.
  - Required: a pulse issued during SW_HOLD is ignored.
- DRAM_ENABLE=0.
  - Required: dram_rstnn constant 0; state never equals 4; core_rstnn rises 8 cycles after peri_rstnn's REL_PERI stage ends.
- rst_system asserted for 1 cycle mid-WAIT_CALIB, and separately coincident with sw_reset_req and lock loss.
  - Required: next edge all outputs 0, calib_timeout=0, state=0; restart follows the nominal sequence.
